// File: rtl/lsu.sv
// Load/store unit: RV32I byte-addressed loads/stores onto a word-indexed data_mem, RMW for sub-word stores.
// Response 1 cycle after acceptance (2 when split); req_ready only in IDLE, requests seen while busy are dropped.
module lsu #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_w_en,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q;

  logic [1:0]  off;
  logic [29:0] w0;
  logic [29:0] w1;
  logic [2:0]  size;
  logic [3:0]  size_ones;
  logic        illegal;
  logic        span;
  logic        err;
  logic [7:0]  mask;
  logic [63:0] shifted;
  logic [3:0]  wmask;
  logic [31:0] wbytes;
  logic [31:0] merged;
  logic [31:0] ld_lo;
  logic [31:0] ld_hi;
  logic [31:0] ld_win;
  logic [31:0] ld_res;

  assign req_ready = (state == IDLE);

  always_comb begin
    size      = 3'd1;
    size_ones = 4'b0001;
    illegal   = 1'b0;
    case (f3_q[1:0])
      2'b00:   begin size = 3'd1; size_ones = 4'b0001; end
      2'b01:   begin size = 3'd2; size_ones = 4'b0011; end
      2'b10:   begin size = 3'd4; size_ones = 4'b1111; end
      default: illegal = 1'b1;
    endcase
    // Only LW exists for the 4-byte size; stores have no unsigned variants.
    if (f3_q == 3'b110) illegal = 1'b1;
    if (we_q && f3_q[2]) illegal = 1'b1;
  end

  assign off     = addr_q[1:0];
  assign w0      = addr_q[31:2];
  assign w1      = w0 + 30'd1;
  assign span    = ({2'b00, off} + {1'b0, size}) > 4'd4;
  assign err     = illegal || (span && !MISALIGN_EN);
  assign mask    = {4'b0000, size_ones} << off;
  assign shifted = {32'b0, wdata_q} << {off, 3'b000};

  // Byte merge for the read-modify-write; ACC1 uses the upper half of the shifted lane.
  always_comb begin
    wmask  = (state == ACC1) ? mask[7:4] : mask[3:0];
    wbytes = (state == ACC1) ? shifted[63:32] : shifted[31:0];
    merged = mem_r_data;
    for (int i = 0; i < 4; i++) begin
      if (wmask[i]) merged[8*i +: 8] = wbytes[8*i +: 8];
    end
  end

  always_comb begin
    mem_addr   = 32'd0;
    mem_w_en   = 1'b0;
    mem_w_data = 32'd0;
    case (state)
      ACC0: begin
        mem_addr = {2'b00, w0};
        if (we_q && !err) begin
          mem_w_en   = |mask[3:0];
          mem_w_data = merged;
        end
      end
      ACC1: begin
        mem_addr = {2'b00, w1};
        if (we_q) begin
          mem_w_en   = |mask[7:4];
          mem_w_data = merged;
        end
      end
      default: ;
    endcase
  end

  // In ACC0 the low word is still on mem_r_data; it is only in lo_q once ACC1 runs.
  always_comb begin
    ld_lo  = (state == ACC1) ? lo_q : mem_r_data;
    ld_hi  = (state == ACC1) ? mem_r_data : 32'd0;
    ld_win = 32'({ld_hi, ld_lo} >> {off, 3'b000});
    ld_res = 32'd0;
    if (!we_q && !err) begin
      case (f3_q)
        3'b000:  ld_res = {{24{ld_win[7]}}, ld_win[7:0]};
        3'b100:  ld_res = {24'd0, ld_win[7:0]};
        3'b001:  ld_res = {{16{ld_win[15]}}, ld_win[15:0]};
        3'b101:  ld_res = {16'd0, ld_win[15:0]};
        3'b010:  ld_res = ld_win;
        default: ld_res = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      lo_q       <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            state   <= ACC0;
          end
        end
        ACC0: begin
          lo_q <= mem_r_data;
          if (span && !err) begin
            state <= ACC1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= ld_res;
            resp_err   <= err;
          end
        end
        ACC1: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= ld_res;
          resp_err   <= 1'b0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: two instances (split enabled / disabled) share one small word memory model.
module tb_lsu;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid_a, req_valid_b, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        sel;

  logic        ready_a, ready_b, rv_a, rv_b, err_a, err_b, wen_a, wen_b;
  logic [31:0] rd_a, rd_b, maddr_a, maddr_b, wd_a, wd_b;

  logic        req_ready, resp_valid, resp_err, mem_w_en;
  logic [31:0] resp_rdata, mem_addr, mem_w_data, mem_r_data;

  assign req_ready  = sel ? ready_b : ready_a;
  assign resp_valid = sel ? rv_b    : rv_a;
  assign resp_err   = sel ? err_b   : err_a;
  assign resp_rdata = sel ? rd_b    : rd_a;
  assign mem_addr   = sel ? maddr_b : maddr_a;
  assign mem_w_en   = sel ? wen_b   : wen_a;
  assign mem_w_data = sel ? wd_b    : wd_a;

  logic [31:0] mem [0:7];
  logic        preload;
  int          wr_cnt = 0;
  logic [31:0] wr_log [0:15];

  assign mem_r_data = mem[mem_addr[2:0]];

  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 32'h88776655;
      mem[1] <= 32'h44332211;
      mem[2] <= 32'hCAFEF00D;
      for (int i = 3; i < 8; i++) mem[i] <= 32'd0;
    end else if (mem_w_en) begin
      mem[mem_addr[2:0]]   <= mem_w_data;
      wr_log[wr_cnt[3:0]] <= mem_addr;
      wr_cnt              <= wr_cnt + 1;
    end
  end

  lsu #(.MISALIGN_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_a), .req_ready(ready_a), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_a), .resp_rdata(rd_a), .resp_err(err_a),
    .mem_addr(maddr_a), .mem_w_en(wen_a), .mem_w_data(wd_a), .mem_r_data(mem_r_data)
  );

  lsu #(.MISALIGN_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(ready_b), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_b), .resp_rdata(rd_b), .resp_err(err_b),
    .mem_addr(maddr_b), .mem_w_en(wen_b), .mem_w_data(wd_b), .mem_r_data(mem_r_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_preload();
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
  endtask

  // One request on the selected instance; checks handshake, addresses, latency, result and write count.
  task automatic run(input string tag, input logic which, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_wr);
    int lat;
    int w_start;
    sel = which;
    #0;
    chk({tag, " ready_idle"}, 32'(req_ready), 32'd1);
    w_start    = wr_cnt;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    if (which) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    chk({tag, " ready_busy"}, 32'(req_ready), 32'd0);
    chk({tag, " addr_w0"}, mem_addr, {2'b00, addr[31:2]});
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!resp_valid && lat == 1)
        chk({tag, " addr_w1"}, mem_addr, {2'b00, addr[31:2] + 30'd1});
    end while (!resp_valid && lat < 6);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rdata"}, resp_rdata, exp_rd);
    chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
    chk({tag, " writes"}, 32'(wr_cnt - w_start), 32'(exp_wr));
    @(posedge clk); #1;
    chk({tag, " valid_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, " ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int   ws;
    logic seen_v;
    rst_n       = 1'b0;
    sel         = 1'b0;
    preload     = 1'b0;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_we      = 1'b0;
    req_funct3  = 3'd0;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    #12;
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset valid", 32'(resp_valid), 32'd0);
    chk("reset rdata", resp_rdata, 32'd0);
    chk("reset err", 32'(resp_err), 32'd0);
    chk("reset wen", 32'(mem_w_en), 32'd0);
    chk("reset maddr", mem_addr, 32'd0);
    chk("reset wdata", mem_w_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_preload();

    run("lw0",   1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1, 32'h88776655, 1'b0, 0);
    run("lb3",   1'b0, 1'b0, 3'b000, 32'h3, 32'h0, 1, 32'hFFFFFF88, 1'b0, 0);
    run("lbu3",  1'b0, 1'b0, 3'b100, 32'h3, 32'h0, 1, 32'h00000088, 1'b0, 0);
    run("lh2",   1'b0, 1'b0, 3'b001, 32'h2, 32'h0, 1, 32'hFFFF8877, 1'b0, 0);
    run("lh3",   1'b0, 1'b0, 3'b001, 32'h3, 32'h0, 2, 32'h00001188, 1'b0, 0);
    run("lw1",   1'b0, 1'b0, 3'b010, 32'h1, 32'h0, 2, 32'h11887766, 1'b0, 0);

    run("sb5",   1'b0, 1'b1, 3'b000, 32'h5, 32'h000000AB, 1, 32'h0, 1'b0, 1);
    chk("sb5 mem1", mem[1], 32'h4433AB11);
    chk("sb5 mem0", mem[0], 32'h88776655);

    do_preload();
    ws = wr_cnt;
    run("sw6",   1'b0, 1'b1, 3'b010, 32'h6, 32'hDEADBEEF, 2, 32'h0, 1'b0, 2);
    chk("sw6 mem1", mem[1], 32'hBEEF2211);
    chk("sw6 mem2", mem[2], 32'hCAFEDEAD);
    chk("sw6 order0", wr_log[4'(ws)], 32'd1);
    chk("sw6 order1", wr_log[4'(ws + 1)], 32'd2);

    run("f3_011",  1'b0, 1'b0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0);
    run("sbu_ill", 1'b0, 1'b1, 3'b100, 32'h4, 32'h55, 1, 32'h0, 1'b1, 0);
    chk("sbu_ill mem1", mem[1], 32'hBEEF2211);

    run("nosplit lw1", 1'b1, 1'b0, 3'b010, 32'h1, 32'h0, 1, 32'h0, 1'b1, 0);
    run("nosplit sw6", 1'b1, 1'b1, 3'b010, 32'h6, 32'h12345678, 1, 32'h0, 1'b1, 0);
    chk("nosplit mem2", mem[2], 32'hCAFEDEAD);
    run("nosplit lw4", 1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 1, 32'hBEEF2211, 1'b0, 0);

    // Reset pulse while the upper word of a split store is being written.
    do_preload();
    sel        = 1'b0;
    ws         = wr_cnt;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h6;
    req_wdata  = 32'hDEADBEEF;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    @(posedge clk); #1;
    chk("rst acc1 wen", 32'(mem_w_en), 32'd1);
    chk("rst acc1 addr", mem_addr, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst wen_drop", 32'(mem_w_en), 32'd0);
    chk("rst ready", 32'(req_ready), 32'd1);
    seen_v = 1'b0;
    @(posedge clk); #1;
    if (resp_valid) seen_v = 1'b1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (resp_valid) seen_v = 1'b1;
    end
    chk("rst no_resp", 32'(seen_v), 32'd0);
    chk("rst mem2", mem[2], 32'hCAFEF00D);
    chk("rst mem1", mem[1], 32'hBEEF2211);
    chk("rst writes", 32'(wr_cnt - ws), 32'd1);
    chk("rst ready_after", 32'(req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
